// File: rtl/bit_clmul_issue.sv
// bit_clmul_issue: issue/retire controller for the multi-cycle carry-less
// multiply unit (clmul / clmulh / clmulr) in the execute stage.
// It launches one operation at a time into the unit and stalls the pipeline
// until the result is back. A one-entry result cache lets an identical
// back-to-back operation retire in the same cycle without using the unit.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   ex_valid/op/rdata1/2    execute-stage request (op is one-hot {r,h,l})
//   ex_clear                flush, kills the execute-stage instruction
//   stall                   hold execute stage and everything upstream
//   wb_valid, wb_result     one-cycle result pulse to writeback
//   clmul_enable/op/rdata*  start pulse and operands to the clmul unit
//   clmul_result/ready      result and one-cycle done pulse from the unit
module bit_clmul_issue #(
    parameter int unsigned XLEN     = 32,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [2:0]      ex_op,
    input  logic [XLEN-1:0] ex_rdata1,
    input  logic [XLEN-1:0] ex_rdata2,
    input  logic            ex_clear,
    output logic            stall,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_result,
    output logic            clmul_enable,
    output logic [2:0]      clmul_op,
    output logic [XLEN-1:0] clmul_rdata1,
    output logic [XLEN-1:0] clmul_rdata2,
    input  logic [XLEN-1:0] clmul_result,
    input  logic            clmul_ready
);
    localparam int unsigned OP_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // operation currently held by the unit
    logic [OP_W-1:0] lat_op;
    logic [XLEN-1:0] lat_rdata1;
    logic [XLEN-1:0] lat_rdata2;

    // one-entry result cache
    logic            cache_valid;
    logic [OP_W-1:0] cache_op;
    logic [XLEN-1:0] cache_rdata1;
    logic [XLEN-1:0] cache_rdata2;
    logic [XLEN-1:0] cache_result;

    logic op_onehot;
    logic req;
    logic hit;
    logic issue;
    logic cache_wr;

    // multi-hot ops are treated as "not a clmul op"
    assign op_onehot = (ex_op == 3'b001) || (ex_op == 3'b010) || (ex_op == 3'b100);
    assign req       = ex_valid & ~ex_clear & op_onehot;
    assign hit       = CACHE_EN & cache_valid & (cache_op == ex_op)
                     & (cache_rdata1 == ex_rdata1) & (cache_rdata2 == ex_rdata2);

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req && !hit) next_state = S_BUSY;
            end
            S_BUSY: begin
                if (clmul_ready && !ex_clear)      next_state = S_DONE;
                else if (ex_clear && !clmul_ready) next_state = S_DRAIN;
                else if (ex_clear)                 next_state = S_IDLE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            S_DRAIN: begin
                // killed op still in the unit; wait it out before reissuing
                if (clmul_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // outputs and datapath strobes; everything forced to 0 while in reset
    always_comb begin
        stall        = 1'b0;
        wb_valid     = 1'b0;
        wb_result    = '0;
        clmul_enable = 1'b0;
        clmul_op     = '0;
        clmul_rdata1 = '0;
        clmul_rdata2 = '0;
        issue        = 1'b0;
        cache_wr     = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    if (req && hit) begin
                        wb_valid  = 1'b1;
                        wb_result = cache_result;
                    end else if (req) begin
                        issue        = 1'b1;
                        clmul_enable = 1'b1;
                        clmul_op     = ex_op;
                        clmul_rdata1 = ex_rdata1;
                        clmul_rdata2 = ex_rdata2;
                        stall        = 1'b1;
                    end
                end
                S_BUSY: begin
                    stall        = ~ex_clear;
                    clmul_op     = lat_op;
                    clmul_rdata1 = lat_rdata1;
                    clmul_rdata2 = lat_rdata2;
                    cache_wr     = clmul_ready & ~ex_clear;
                end
                S_DONE: begin
                    wb_valid  = ~ex_clear;
                    wb_result = ex_clear ? '0 : cache_result;
                end
                S_DRAIN: begin
                    // a new op waits here and does not consult the cache
                    stall        = ex_valid & op_onehot & ~ex_clear;
                    clmul_op     = lat_op;
                    clmul_rdata1 = lat_rdata1;
                    clmul_rdata2 = lat_rdata2;
                end
                default: ;
            endcase
        end
    end

    // operand latch and result cache
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_op       <= '0;
            lat_rdata1   <= '0;
            lat_rdata2   <= '0;
            cache_valid  <= 1'b0;
            cache_op     <= '0;
            cache_rdata1 <= '0;
            cache_rdata2 <= '0;
            cache_result <= '0;
        end else begin
            if (issue) begin
                lat_op     <= ex_op;
                lat_rdata1 <= ex_rdata1;
                lat_rdata2 <= ex_rdata2;
            end
            if (cache_wr) begin
                cache_valid  <= 1'b1;
                cache_op     <= lat_op;
                cache_rdata1 <= lat_rdata1;
                cache_rdata2 <= lat_rdata2;
                cache_result <= clmul_result;
            end
        end
    end

endmodule

// File: tb/tb_bit_clmul_issue.sv
// Testbench for bit_clmul_issue. Two instances share the execute-stage
// inputs: index 0 has the result cache enabled, index 1 has it disabled.
// Each instance gets its own model of the clmul unit, and a transaction-level
// model of the controller is checked against the outputs every cycle.
module tb_bit_clmul_issue;
    localparam int unsigned XLEN = 32;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_RET   = 2;
    localparam int M_DRAIN = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic            ex_valid;
    logic [2:0]      ex_op;
    logic [XLEN-1:0] ex_rdata1;
    logic [XLEN-1:0] ex_rdata2;
    logic            ex_clear;

    logic            stall_s        [2];
    logic            wb_valid_s     [2];
    logic [XLEN-1:0] wb_result_s    [2];
    logic            clmul_enable_s [2];
    logic [2:0]      clmul_op_s     [2];
    logic [XLEN-1:0] clmul_rdata1_s [2];
    logic [XLEN-1:0] clmul_rdata2_s [2];
    logic [XLEN-1:0] clmul_result_s [2];
    logic            clmul_ready_s  [2];

    bit_clmul_issue #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_clear(ex_clear),
        .stall(stall_s[0]), .wb_valid(wb_valid_s[0]), .wb_result(wb_result_s[0]),
        .clmul_enable(clmul_enable_s[0]), .clmul_op(clmul_op_s[0]),
        .clmul_rdata1(clmul_rdata1_s[0]), .clmul_rdata2(clmul_rdata2_s[0]),
        .clmul_result(clmul_result_s[0]), .clmul_ready(clmul_ready_s[0])
    );

    bit_clmul_issue #(.XLEN(XLEN), .CACHE_EN(1'b0)) dut_nc (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_clear(ex_clear),
        .stall(stall_s[1]), .wb_valid(wb_valid_s[1]), .wb_result(wb_result_s[1]),
        .clmul_enable(clmul_enable_s[1]), .clmul_op(clmul_op_s[1]),
        .clmul_rdata1(clmul_rdata1_s[1]), .clmul_rdata2(clmul_rdata2_s[1]),
        .clmul_result(clmul_result_s[1]), .clmul_ready(clmul_ready_s[1])
    );

    int n_pass  = 0;
    int n_total = 0;
    int lat_max = 0;   // 0: fixed 33-cycle unit, otherwise random 1..lat_max

    // controller model state
    int              m_mode  [2] = '{M_IDLE, M_IDLE};
    bit              c_valid [2] = '{1'b0, 1'b0};
    logic [2:0]      c_op    [2];
    logic [XLEN-1:0] c_a     [2];
    logic [XLEN-1:0] c_b     [2];
    logic [XLEN-1:0] c_res   [2];
    logic [2:0]      l_op    [2];
    logic [XLEN-1:0] l_a     [2];
    logic [XLEN-1:0] l_b     [2];

    // clmul unit model state
    bit              u_busy   [2] = '{1'b0, 1'b0};
    int              u_rem    [2] = '{0, 0};
    logic [XLEN-1:0] u_res    [2];
    logic            n_ready  [2] = '{1'b0, 1'b0};
    logic [XLEN-1:0] n_result [2] = '{32'h0, 32'h0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for wb_valid, want a result", name);
    endtask

    // carry-less product from its definition: XOR of shifted copies of a
    function automatic logic [XLEN-1:0] clmul_ref(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = '0;
        for (int i = 0; i < XLEN; i++)
            if (b[i]) p = p ^ ((2*XLEN)'(a) << i);
        case (op)
            3'b001:  return p[XLEN-1:0];
            3'b010:  return p[2*XLEN-1:XLEN];
            3'b100:  return p[2*XLEN-2:XLEN-1];
            default: return '0;
        endcase
    endfunction

    // one cycle of the controller model + unit model for instance k
    task automatic model_step(input int k);
        logic e_stall, e_wbv, e_en;
        logic [2:0] e_op;
        logic [XLEN-1:0] e_wbr, e_a, e_b;
        bit bus_def, onehot, req, hit;
        int lat;
        e_stall = 1'b0; e_wbv = 1'b0; e_en = 1'b0;
        e_op = '0; e_wbr = '0; e_a = '0; e_b = '0;
        bus_def = 1'b1;
        onehot = (ex_op == 3'b001) || (ex_op == 3'b010) || (ex_op == 3'b100);
        req = ex_valid && !ex_clear && onehot;
        if (reset) begin
            m_mode[k]  = M_IDLE;
            c_valid[k] = 1'b0;
        end else begin
            case (m_mode[k])
                M_IDLE: begin
                    hit = (k == 0) && c_valid[k] && c_op[k] == ex_op
                          && c_a[k] == ex_rdata1 && c_b[k] == ex_rdata2;
                    if (req && hit) begin
                        e_wbv = 1'b1;
                        e_wbr = c_res[k];
                    end else if (req) begin
                        e_en = 1'b1; e_stall = 1'b1;
                        e_op = ex_op; e_a = ex_rdata1; e_b = ex_rdata2;
                        l_op[k] = ex_op; l_a[k] = ex_rdata1; l_b[k] = ex_rdata2;
                        m_mode[k] = M_RUN;
                    end
                end
                M_RUN: begin
                    e_stall = !ex_clear;
                    e_op = l_op[k]; e_a = l_a[k]; e_b = l_b[k];
                    if (clmul_ready_s[k] && !ex_clear) begin
                        c_valid[k] = 1'b1;
                        c_op[k] = l_op[k]; c_a[k] = l_a[k]; c_b[k] = l_b[k];
                        c_res[k] = clmul_ref(l_op[k], l_a[k], l_b[k]);
                        m_mode[k] = M_RET;
                    end else if (ex_clear) begin
                        m_mode[k] = clmul_ready_s[k] ? M_IDLE : M_DRAIN;
                    end
                end
                M_RET: begin
                    bus_def = 1'b0;
                    e_wbv = !ex_clear;
                    e_wbr = e_wbv ? c_res[k] : '0;
                    m_mode[k] = M_IDLE;
                end
                default: begin
                    bus_def = 1'b0;
                    e_stall = ex_valid && onehot && !ex_clear;
                    if (clmul_ready_s[k]) m_mode[k] = M_IDLE;
                end
            endcase
        end
        chk($sformatf("stall[%0d]", k), 64'(stall_s[k]), 64'(e_stall));
        chk($sformatf("wb_valid[%0d]", k), 64'(wb_valid_s[k]), 64'(e_wbv));
        chk($sformatf("wb_result[%0d]", k), 64'(wb_result_s[k]), 64'(e_wbr));
        chk($sformatf("clmul_enable[%0d]", k), 64'(clmul_enable_s[k]), 64'(e_en));
        if (bus_def) begin
            chk($sformatf("clmul_op[%0d]", k), 64'(clmul_op_s[k]), 64'(e_op));
            chk($sformatf("clmul_rdata1[%0d]", k), 64'(clmul_rdata1_s[k]), 64'(e_a));
            chk($sformatf("clmul_rdata2[%0d]", k), 64'(clmul_rdata2_s[k]), 64'(e_b));
        end

        // unit: result for what was actually sent, ready lat cycles after enable
        if (reset) begin
            u_busy[k] = 1'b0;
            n_ready[k] = 1'b0;
        end else if (clmul_enable_s[k]) begin
            lat = (lat_max == 0) ? 33 : int'($urandom_range(1, lat_max));
            u_busy[k] = 1'b1;
            u_rem[k] = lat - 1;
            u_res[k] = clmul_ref(clmul_op_s[k], clmul_rdata1_s[k], clmul_rdata2_s[k]);
            n_ready[k] = (u_rem[k] == 0);
        end else if (u_busy[k]) begin
            if (u_rem[k] == 0) begin
                u_busy[k] = 1'b0;
                n_ready[k] = 1'b0;
            end else begin
                u_rem[k]--;
                n_ready[k] = (u_rem[k] == 0);
            end
        end else begin
            n_ready[k] = 1'b0;
        end
        n_result[k] = n_ready[k] ? u_res[k] : $urandom();
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    always @(posedge clock) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            clmul_ready_s[k]  = n_ready[k];
            clmul_result_s[k] = n_result[k];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic clr);
        ex_valid = v; ex_op = op; ex_rdata1 = a; ex_rdata2 = b; ex_clear = clr;
    endtask

    // counts cycles from the current one until instance 0 pulses wb_valid
    task automatic wait_wb(output logic [XLEN-1:0] res, output int cyc);
        cyc = 0;
        res = '0;
        forever begin
            @(negedge clock);
            if (wb_valid_s[0]) begin
                res = wb_result_s[0];
                break;
            end
            cyc++;
            if (cyc > 300) begin
                fail_timeout("wait_wb");
                break;
            end
            step();
        end
        step();
        drive(1'b0, 3'b000, '0, '0, 1'b0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, output logic [XLEN-1:0] res,
                          output int cyc);
        drive(1'b1, op, a, b, 1'b0);
        wait_wb(res, cyc);
    endtask

    function automatic logic [XLEN-1:0] pick_opnd();
        case ($urandom_range(0, 3))
            0:       return 32'h3;
            1:       return 32'h8000_0000;
            2:       return 32'h5;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [XLEN-1:0] res;
        logic [2:0] op_tab [10];
        int cyc;
        int got;
        op_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b111};

        reset = 1'b1;
        drive(1'b0, 3'b000, '0, '0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset stall", 64'(stall_s[0]), 64'd0);
        chk("reset enable", 64'(clmul_enable_s[0]), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("post-reset stall", 64'(stall_s[0]), 64'd0);
        chk("post-reset wb_valid", 64'(wb_valid_s[0]), 64'd0);
        step();

        // plain miss
        run_op(3'b001, 32'h3, 32'h3, res, cyc);
        chk("clmul 3x3 result", 64'(res), 64'h5);
        chk("clmul 3x3 latency", 64'(cyc), 64'd34);

        // immediate repeat: hit on instance 0, full miss on instance 1
        drive(1'b1, 3'b001, 32'h3, 32'h3, 1'b0);
        @(negedge clock);
        chk("hit wb_valid", 64'(wb_valid_s[0]), 64'd1);
        chk("hit wb_result", 64'(wb_result_s[0]), 64'h5);
        chk("hit stall", 64'(stall_s[0]), 64'd0);
        chk("hit enable", 64'(clmul_enable_s[0]), 64'd0);
        chk("nocache enable", 64'(clmul_enable_s[1]), 64'd1);
        step();
        drive(1'b0, 3'b000, '0, '0, 1'b0);
        got = -1;
        for (int c = 1; c < 100; c++) begin
            @(negedge clock);
            if (wb_valid_s[1]) begin
                got = c;
                res = wb_result_s[1];
                break;
            end
            step();
        end
        if (got < 0) fail_timeout("nocache wb");
        else begin
            chk("nocache latency", 64'(got), 64'd34);
            chk("nocache result", 64'(res), 64'h5);
        end
        step();

        run_op(3'b010, 32'h8000_0000, 32'h2, res, cyc);
        chk("clmulh result", 64'(res), 64'h1);
        run_op(3'b100, 32'h8000_0000, 32'h2, res, cyc);
        chk("clmulr result", 64'(res), 64'h2);
        chk("clmulr latency", 64'(cyc), 64'd34);

        // flush while busy, new op waits for the drained unit
        got = -1;
        for (int c = 0; c < 120; c++) begin
            if (c == 10)      drive(1'b1, 3'b001, 32'h7, 32'h9, 1'b1);
            else if (c == 11) drive(1'b0, 3'b000, '0, '0, 1'b0);
            else if (c >= 12) drive(1'b1, 3'b001, 32'h5, 32'h1, 1'b0);
            else              drive(1'b1, 3'b001, 32'h7, 32'h9, 1'b0);
            @(negedge clock);
            if (c == 10) chk("flush stall", 64'(stall_s[0]), 64'd0);
            if (c == 33) chk("drain stall", 64'(stall_s[0]), 64'd1);
            if (c == 34) chk("reissue enable", 64'(clmul_enable_s[0]), 64'd1);
            if (c >= 12 && wb_valid_s[0]) begin
                got = c;
                res = wb_result_s[0];
                break;
            end
            step();
        end
        if (got < 0) fail_timeout("flush reissue");
        else begin
            chk("flush reissue cycle", 64'(got), 64'd68);
            chk("flush reissue result", 64'(res), 64'h5);
        end
        step();
        drive(1'b0, 3'b000, '0, '0, 1'b0);
        // killed 7x9 was never cached, so it misses
        run_op(3'b001, 32'h7, 32'h9, res, cyc);
        chk("killed op latency", 64'(cyc), 64'd34);
        chk("killed op result", 64'(res), 64'h3f);

        // flush on the same cycle as ready
        for (int c = 0; c <= 34; c++) begin
            drive(1'b1, 3'b001, 32'ha, 32'h3, c == 33);
            @(negedge clock);
            if (c == 33) chk("clear+ready stall", 64'(stall_s[0]), 64'd0);
            if (c == 34) begin
                chk("clear+ready no wb", 64'(wb_valid_s[0]), 64'd0);
                chk("clear+ready reissue", 64'(clmul_enable_s[0]), 64'd1);
            end
            if (c < 34) step();
        end
        step();
        drive(1'b0, 3'b000, '0, '0, 1'b0);
        wait_wb(res, cyc);
        chk("clear+ready rerun result", 64'(res), 64'h1e);
        chk("clear+ready rerun latency", 64'(cyc), 64'd33);

        // reset in the middle of a busy op
        for (int c = 0; c <= 6; c++) begin
            if (c < 5) drive(1'b1, 3'b100, 32'h1234, 32'h5678, 1'b0);
            else       drive(1'b0, 3'b000, '0, '0, 1'b0);
            reset = (c == 5);
            @(negedge clock);
            if (c >= 5) begin
                chk($sformatf("rst%0d stall", c), 64'(stall_s[0]), 64'd0);
                chk($sformatf("rst%0d op", c), 64'(clmul_op_s[0]), 64'd0);
                chk($sformatf("rst%0d wb", c), 64'(wb_valid_s[0]), 64'd0);
            end
            step();
        end
        run_op(3'b001, 32'ha, 32'h3, res, cyc);
        chk("post-reset miss latency", 64'(cyc), 64'd34);
        chk("post-reset miss result", 64'(res), 64'h1e);

        // multi-hot op is ignored
        drive(1'b1, 3'b011, 32'h3, 32'h3, 1'b0);
        @(negedge clock);
        chk("illegal stall", 64'(stall_s[0]), 64'd0);
        chk("illegal enable", 64'(clmul_enable_s[0]), 64'd0);
        chk("illegal wb", 64'(wb_valid_s[0]), 64'd0);
        step();

        // random traffic with random unit latency
        lat_max = 40;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!(stall_s[0] && $urandom_range(0, 3) != 0)) begin
                ex_valid = ($urandom_range(0, 9) < 7);
                ex_op = op_tab[$urandom_range(0, 9)];
                if ($urandom_range(0, 2) != 0) begin
                    ex_rdata1 = pick_opnd();
                    ex_rdata2 = pick_opnd();
                end
            end
            ex_clear = ($urandom_range(0, 19) == 0);
            step();
        end
        reset = 1'b0;
        drive(1'b0, 3'b000, '0, '0, 1'b0);
        repeat (60) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
